// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with glitch filter, frame checking, timeout and FWFT byte FIFO.
// Odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            io_keyboard_kb_clk,
  input  logic                            io_keyboard_kb_data,
  output logic [7:0]                      io_ctrl_data,
  output logic                            io_ctrl_valid,
  input  logic                            io_ctrl_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] io_ctrl_count,
  output logic                            io_ctrl_interrupt,
  output logic                            io_ctrl_overflow,
  output logic                            io_ctrl_frame_err,
  input  logic                            io_ctrl_err_clr
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] ck_sync_q, dt_sync_q;
  logic sclk, sdata;
  logic filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic fall;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic timeout;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic par_ok, push_req, ferr_set;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic full, push, pop, ovf_set;
  logic intr_q, ovf_q, ferr_q;
  // Synchronisers idle high so reset looks like a quiet bus
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
    end else begin
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], io_keyboard_kb_clk};
      dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], io_keyboard_kb_data};
    end
  assign sclk  = ck_sync_q[SYNC_STAGES-1];
  assign sdata = dt_sync_q[SYNC_STAGES-1];
  always_comb begin
    fcnt_d = (sclk == filt_q || fcnt_q == FW'(FILTER_LEN-1)) ? '0 : fcnt_q + FW'(1);
    filt_d = (sclk != filt_q && fcnt_q == FW'(FILTER_LEN-1)) ? sclk : filt_q;
  end
  assign fall = filt_q & ~filt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      tcnt_q <= tcnt_d;
    end
  assign tcnt_d  = (state_q == IDLE || fall) ? '0 : tcnt_q + TW'(1);
  assign timeout = state_q != IDLE && !fall && tcnt_q == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = IDLE;
    else if (fall)
      case (state_q)
        IDLE:    state_d = sdata ? IDLE : DATA;
        DATA:    state_d = (idx_q == 3'd7) ? PARITY : DATA;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    push_req = fall && state_q == STOP && sdata && par_ok;
    ferr_set = timeout || (fall && state_q == STOP && !(sdata && par_ok));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (fall) begin
      if (state_q == IDLE) idx_q <= '0;
      if (state_q == DATA) begin
        shift_q <= {sdata, shift_q[7:1]};
        idx_q   <= idx_q + 3'd1;
      end
    end
`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                         par_q <= 1'b0;
    else if (fall && state_q == PARITY) par_q <= sdata;
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif
  assign full    = count_q == CW'(FIFO_DEPTH);
  assign pop     = io_ctrl_valid && io_ctrl_ready;
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign count_d = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= shift_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      intr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_q  <= count_d;
      intr_q   <= push;
      ovf_q    <= ovf_set ? 1'b1 : io_ctrl_err_clr ? 1'b0 : ovf_q;
      ferr_q   <= ferr_set ? 1'b1 : io_ctrl_err_clr ? 1'b0 : ferr_q;
    end
  assign io_ctrl_valid     = count_q != '0;
  assign io_ctrl_data      = io_ctrl_valid ? mem_q[rd_ptr_q] : '0;
  assign io_ctrl_count     = count_q;
  assign io_ctrl_interrupt = intr_q;
  assign io_ctrl_overflow  = ovf_q;
  assign io_ctrl_frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed table-driven bench for ps2_rx_fifo.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, kb_clk = 1'b1, kb_data = 1'b1, ready = 1'b0, err_clr = 1'b0;
  logic [7:0] data;
  logic valid, intr, ovf, ferr;
  logic [3:0] count;
  int n_chk = 0, n_fail = 0, int_cnt = 0, lat = 7;
  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .io_keyboard_kb_clk(kb_clk), .io_keyboard_kb_data(kb_data),
    .io_ctrl_data(data), .io_ctrl_valid(valid), .io_ctrl_ready(ready), .io_ctrl_count(count),
    .io_ctrl_interrupt(intr), .io_ctrl_overflow(ovf), .io_ctrl_frame_err(ferr),
    .io_ctrl_err_clr(err_clr));
  always #5 clk = ~clk;
  always @(negedge clk) if (intr) int_cnt++;
  typedef struct {
    logic [7:0] d;
    logic bad_par, stop, pop, clr;
    int cnt;
    logic [7:0] head;
    logic ferr, ovf;
    int ints;
  } vec_t;
  vec_t vec [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par, input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction
  // mode 0: plain, 1: measure push latency on the stop bit, 2: pop on the push edge
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      kb_data = bits[i];
      repeat (10) @(negedge clk);
      kb_clk = 1'b0;
      if (i == nbits-1 && mode == 1) begin
        int k = 0;
        while (!intr && k < 20) begin
          @(negedge clk);
          k++;
        end
        lat = k;
        chk("latency_found", 32'(k < 20), 1);
        repeat (20-k) @(negedge clk);
      end else if (i == nbits-1 && mode == 2) begin
        repeat (lat-1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (20-lat) @(negedge clk);
      end else repeat (20) @(negedge clk);
      kb_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    kb_data = 1'b1;
  endtask
  task automatic pulse_pop();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask
  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask
  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, "_head"}, data, exp);
    pulse_pop();
  endtask
  initial begin
    logic [7:0] q [$];
    int i0;
    vec[0] = '{8'h1C, 0, 1, 0, 0, 1, 8'h1C, 0, 0, 1};
    vec[1] = '{8'hF0, 0, 1, 0, 0, 2, 8'h1C, 0, 0, 1};
    vec[2] = '{8'h2A, 0, 1, 1, 0, 2, 8'hF0, 0, 0, 1};
    vec[3] = '{8'h1C, 1, 1, 0, 0, PE ? 2 : 3, 8'hF0, PE, 0, PE ? 0 : 1};
    vec[4] = '{8'h55, 0, 0, 0, 0, PE ? 2 : 3, 8'hF0, 1, 0, 0};
    vec[5] = '{8'h33, 0, 1, 0, 1, PE ? 3 : 4, 8'hF0, 0, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_int", intr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ferr", ferr, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      i0 = int_cnt;
      send_bits(frame(vec[i].d, vec[i].bad_par, vec[i].stop), 11, i == 0 ? 1 : 0);
      if (vec[i].pop) pulse_pop();
      if (vec[i].clr) pulse_clr();
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_count", i), count, vec[i].cnt);
      chk($sformatf("v%0d_valid", i), valid, 1);
      chk($sformatf("v%0d_head", i), data, vec[i].head);
      chk($sformatf("v%0d_ferr", i), ferr, vec[i].ferr);
      chk($sformatf("v%0d_ovf", i), ovf, vec[i].ovf);
      chk($sformatf("v%0d_int", i), int_cnt - i0, vec[i].ints);
    end
    q = PE ? '{8'hF0, 8'h2A, 8'h33} : '{8'hF0, 8'h2A, 8'h1C, 8'h33};
    foreach (q[k]) pop_chk($sformatf("order%0d", k), q[k]);
    chk("empty_count", count, 0);
    chk("empty_valid", valid, 0);
    chk("empty_data", data, 0);
    pulse_pop();
    chk("pop_empty_count", count, 0);
    // Start plus three data bits, then the bus stalls
    send_bits(frame(8'h2A, 0, 1), 4, 0);
    repeat (TMO + 200) @(negedge clk);
    chk("tmo_ferr", ferr, 1);
    chk("tmo_count", count, 0);
    pulse_clr();
    chk("clr_ferr", ferr, 0);
    send_bits(frame(8'h2A, 0, 1), 11, 0);
    repeat (3) @(negedge clk);
    chk("tmo_next_count", count, 1);
    chk("tmo_next_head", data, 8'h2A);
    chk("tmo_next_ferr", ferr, 0);
    pulse_pop();
    // Sub-threshold low glitch with data low must not look like a start bit
    @(negedge clk); kb_data = 1'b0; kb_clk = 1'b0;
    repeat (3) @(negedge clk);
    kb_clk = 1'b1;
    repeat (30) @(negedge clk);
    kb_data = 1'b1;
    send_bits(frame(8'h6B, 0, 1), 11, 0);
    repeat (3) @(negedge clk);
    chk("glitch_count", count, 1);
    chk("glitch_head", data, 8'h6B);
    chk("glitch_ferr", ferr, 0);
    pulse_pop();
    i0 = int_cnt;
    for (int b = 1; b <= DEPTH + 1; b++) send_bits(frame(8'(b), 0, 1), 11, 0);
    repeat (3) @(negedge clk);
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", ovf, 1);
    chk("ovf_head", data, 8'h01);
    chk("ovf_ints", int_cnt - i0, DEPTH);
    pulse_clr();
    chk("ovf_clr", ovf, 0);
    i0 = int_cnt;
    send_bits(frame(8'h0A, 0, 1), 11, 2);
    repeat (3) @(negedge clk);
    chk("pp_count", count, DEPTH);
    chk("pp_ovf", ovf, 0);
    chk("pp_int", int_cnt - i0, 1);
    for (int b = 2; b <= DEPTH; b++) pop_chk($sformatf("pp%0d", b), 8'(b));
    pop_chk("pp_last", 8'h0A);
    chk("pp_empty", valid, 0);
    send_bits(frame(8'h77, 0, 1), 11, 0);
    send_bits(frame(8'h2A, 0, 1), 5, 0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 0);
    chk("arst_ferr", ferr, 0);
    @(negedge clk); rst_n = 1'b1;
    send_bits(frame(8'h2A, 0, 1), 11, 0);
    repeat (3) @(negedge clk);
    chk("arst_next_head", data, 8'h2A);
    chk("arst_next_ferr", ferr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
